// File: rtl/lcd_bias_pwm_multi.sv
// Multi-channel left-aligned PWM for LCD bias/contrast, with a shared phase counter,
// a prescaler, a global enable and shadow levels reloaded only at period boundaries.
module lcd_bias_pwm_multi #(
  parameter int                  CHANNELS = 4,
  parameter int                  LEVEL_W  = 2,
  parameter int                  DIV_W    = 8,
  parameter logic [CHANNELS-1:0] INVERT   = {CHANNELS{1'b0}}
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          en,
  input  logic [DIV_W-1:0]              prescale,
  input  logic [CHANNELS*LEVEL_W-1:0]   level,
  output logic [CHANNELS-1:0]           pwm_out,
  output logic                          period_start
);

  localparam int MAXL = (1 << LEVEL_W) - 1;
  localparam logic [LEVEL_W-1:0] LAST_PHASE = LEVEL_W'(MAXL - 1);

  logic [DIV_W-1:0]                 div_q, div_d;
  logic [LEVEL_W-1:0]               phase_q, phase_d;
  logic [CHANNELS-1:0][LEVEL_W-1:0] shadow_q, shadow_d;
  logic                             armed_q, armed_d;
  logic                             pstart_q, pstart_d;
  logic [CHANNELS-1:0]              pwm_q, pwm_d;
  logic                             tick;

  always_comb begin
    div_d    = div_q;
    phase_d  = phase_q;
    shadow_d = shadow_q;
    armed_d  = armed_q;
    pstart_d = 1'b0;
    tick     = (div_q >= prescale);

    if (!en) begin
      div_d   = '0;
      phase_d = '0;
      armed_d = 1'b0;
    end else if (!armed_q) begin
      shadow_d = level;
      phase_d  = '0;
      div_d    = '0;
      armed_d  = 1'b1;
      pstart_d = 1'b1;
    end else if (tick) begin
      div_d = '0;
      if (phase_q == LAST_PHASE) begin
        phase_d  = '0;
        shadow_d = level;
        pstart_d = 1'b1;
      end else begin
        phase_d = phase_q + LEVEL_W'(1);
      end
    end else begin
      div_d = div_q + DIV_W'(1);
    end

    // Output flop is loaded from next-state values so it lines up with phase_q.
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      pwm_d[i] = (armed_d && (phase_d < shadow_d[i])) ^ INVERT[i];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_q    <= '0;
      phase_q  <= '0;
      shadow_q <= '0;
      armed_q  <= 1'b0;
      pstart_q <= 1'b0;
      pwm_q    <= INVERT;
    end else begin
      div_q    <= div_d;
      phase_q  <= phase_d;
      shadow_q <= shadow_d;
      armed_q  <= armed_d;
      pstart_q <= pstart_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = pstart_q;

endmodule

// File: tb/tb_lcd_bias_pwm_multi.sv
// Bench for lcd_bias_pwm_multi: three instances (defaults, inverted ch0, 3-bit levels)
// checked every cycle against a period/phase model plus directed literal patterns.
module tb_lcd_bias_pwm_multi;

  logic       clk = 1'b0;
  logic       rstn, en;
  logic [7:0] prescale;
  logic [7:0] lvl0, lvl1;
  logic [5:0] lvl2;
  logic [3:0] pwm0, pwm1;
  logic [1:0] pwm2;
  logic       ps0, ps1, ps2;

  always #5 clk = ~clk;

  lcd_bias_pwm_multi u_def (
    .clk(clk), .rstn(rstn), .en(en), .prescale(prescale),
    .level(lvl0), .pwm_out(pwm0), .period_start(ps0));

  lcd_bias_pwm_multi #(.INVERT(4'b0001)) u_inv (
    .clk(clk), .rstn(rstn), .en(en), .prescale(prescale),
    .level(lvl1), .pwm_out(pwm1), .period_start(ps1));

  lcd_bias_pwm_multi #(.CHANNELS(2), .LEVEL_W(3)) u_w3 (
    .clk(clk), .rstn(rstn), .en(en), .prescale(prescale),
    .level(lvl2), .pwm_out(pwm2), .period_start(ps2));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: a period is MAXL phases, each phase lasting prescale+1 cycles;
  // channel c is high during the first level[c] phases of each period.
  int NCH  [3] = '{4, 4, 2};
  int MAXL [3] = '{3, 3, 7};
  int INVM [3] = '{0, 1, 0};
  int m_run[3], m_phase[3], m_el[3];
  int m_sh [3][4];
  bit m_ps [3];

  function automatic int lv(input int k, input int c);
    case (k)
      0:       return int'((lvl0 >> (2 * c)) & 8'd3);
      1:       return int'((lvl1 >> (2 * c)) & 8'd3);
      default: return int'((lvl2 >> (3 * c)) & 6'd7);
    endcase
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < 3; k++) begin
        m_run[k] <= 0; m_phase[k] <= 0; m_el[k] <= 0; m_ps[k] <= 1'b0;
        for (int c = 0; c < 4; c++) m_sh[k][c] <= 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (!en) begin
          m_run[k] <= 0; m_phase[k] <= 0; m_el[k] <= 0; m_ps[k] <= 1'b0;
        end else if (m_run[k] == 0) begin
          m_run[k] <= 1; m_phase[k] <= 0; m_el[k] <= 0; m_ps[k] <= 1'b1;
          for (int c = 0; c < 4; c++) m_sh[k][c] <= lv(k, c);
        end else if (m_el[k] + 1 >= int'(prescale) + 1) begin
          m_el[k] <= 0;
          if (m_phase[k] + 1 == MAXL[k]) begin
            m_phase[k] <= 0; m_ps[k] <= 1'b1;
            for (int c = 0; c < 4; c++) m_sh[k][c] <= lv(k, c);
          end else begin
            m_phase[k] <= m_phase[k] + 1; m_ps[k] <= 1'b0;
          end
        end else begin
          m_el[k] <= m_el[k] + 1; m_ps[k] <= 1'b0;
        end
      end
    end
  end

  function automatic logic [3:0] exp_pwm(input int k);
    logic [3:0] v = '0;
    for (int c = 0; c < NCH[k]; c++)
      v[c] = ((m_run[k] != 0) && (m_phase[k] < m_sh[k][c])) ^ INVM[k][c];
    return v;
  endfunction

  always @(negedge clk) begin
    chk("model_pwm0", {28'd0, pwm0}, {28'd0, exp_pwm(0)});
    chk("model_ps0",  {31'd0, ps0},  {31'd0, m_ps[0]});
    chk("model_pwm1", {28'd0, pwm1}, {28'd0, exp_pwm(1)});
    chk("model_ps1",  {31'd0, ps1},  {31'd0, m_ps[1]});
    chk("model_pwm2", {30'd0, pwm2}, {28'd0, exp_pwm(2)});
    chk("model_ps2",  {31'd0, ps2},  {31'd0, m_ps[2]});
  end

  function automatic logic chbit(input int k, input int c);
    case (k)
      0:       return pwm0[c];
      1:       return pwm1[c];
      default: return (c < 2) ? pwm2[c] : 1'b0;
    endcase
  endfunction

  function automatic logic psel(input int k);
    case (k)
      0:       return ps0;
      1:       return ps1;
      default: return ps2;
    endcase
  endfunction

  logic [15:0] hist[4];
  logic [15:0] hps;

  // Records n samples (MSB first) starting at the current negedge.
  task automatic collect(input int k, input int n);
    for (int c = 0; c < 4; c++) hist[c] = '0;
    hps = '0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      for (int c = 0; c < 4; c++) hist[c] = {hist[c][14:0], chbit(k, c)};
      hps = {hps[14:0], psel(k)};
    end
  endtask

  task automatic wait_pstart(input int k);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!psel(k) && n < 200);
    if (!psel(k)) chk("wait_pstart_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rstn = 1'b0; en = 1'b0; prescale = 8'd0;
    lvl0 = {2'd3, 2'd2, 2'd1, 2'd0};
    lvl1 = {2'd3, 2'd2, 2'd1, 2'd1};
    lvl2 = {3'd7, 3'd5};
    #12;
    chk("rst_pwm0", {28'd0, pwm0}, 32'h0);
    chk("rst_pwm1", {28'd0, pwm1}, 32'h1);
    chk("rst_ps0",  {31'd0, ps0},  32'h0);
    @(negedge clk) rstn = 1'b1;
    @(negedge clk) en = 1'b1;

    // Basic patterns, prescale 0
    wait_pstart(0);
    collect(0, 3);
    chk("t1_ch0", {16'd0, hist[0]}, 32'b000);
    chk("t1_ch1", {16'd0, hist[1]}, 32'b100);
    chk("t1_ch2", {16'd0, hist[2]}, 32'b110);
    chk("t1_ch3", {16'd0, hist[3]}, 32'b111);
    chk("t1_ps",  {16'd0, hps},     32'b100);
    @(negedge clk);
    collect(1, 3);
    chk("t5_inv_ch0", {16'd0, hist[0]}, 32'b011);
    chk("t5_inv_ch1", {16'd0, hist[1]}, 32'b100);

    // 3-bit level instance
    wait_pstart(2);
    collect(2, 7);
    chk("t6_l5", {16'd0, hist[0]}, 32'b1111100);
    chk("t6_l7", {16'd0, hist[1]}, 32'b1111111);
    @(negedge clk);
    collect(2, 7);
    chk("t6_l7_wrap", {16'd0, hist[1]}, 32'b1111111);

    // Level written at phase 1, then at phase 2
    wait_pstart(0);
    @(negedge clk);
    lvl0[3:2] = 2'd2;
    collect(0, 4);
    chk("t2_ph1", {16'd0, hist[1]}, 32'b0011);
    @(negedge clk);
    lvl0[3:2] = 2'd1;
    collect(0, 4);
    chk("t2_ph2", {16'd0, hist[1]}, 32'b0100);

    // Prescale 2, then dropped to 0 mid-phase
    @(negedge clk);
    prescale = 8'd2; lvl0[3:2] = 2'd2;
    wait_pstart(0);
    collect(0, 10);
    chk("t3_ch1", {16'd0, hist[1]}, 32'b1111110001);
    chk("t3_ps",  {16'd0, hps},     32'b1000000001);
    @(negedge clk);
    prescale = 8'd0;
    collect(0, 4);
    chk("t3_drop_ch1", {16'd0, hist[1]}, 32'b1101);
    chk("t3_drop_ps",  {16'd0, hps},     32'b0001);

    // Enable off mid-period, restart, then disable on a wrap edge
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("t4_idle_pwm0", {28'd0, pwm0}, 32'h0);
    chk("t4_idle_pwm1", {28'd0, pwm1}, 32'h1);
    chk("t4_idle_ps",   {31'd0, ps0},  32'h0);
    @(negedge clk);
    lvl0 = {2'd0, 2'd1, 2'd3, 2'd2};
    en = 1'b1;
    @(negedge clk);
    chk("t4_restart_ps",  {31'd0, ps0},  32'h1);
    chk("t4_restart_pwm", {28'd0, pwm0}, 32'b0111);
    @(negedge clk);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("t4_wrapdis_ps",  {31'd0, ps0},  32'h0);
    chk("t4_wrapdis_pwm", {28'd0, pwm0}, 32'h0);

    // Asynchronous reset during a high pulse
    lvl0 = {2'd3, 2'd2, 2'd1, 2'd0};
    en = 1'b1;
    wait_pstart(0);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("t5_rst_pwm0", {28'd0, pwm0}, 32'h0);
    chk("t5_rst_pwm1", {28'd0, pwm1}, 32'h1);
    chk("t5_rst_pwm2", {30'd0, pwm2}, 32'h0);
    chk("t5_rst_ps",   {31'd0, ps0},  32'h0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (6) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lcd_bias_pwm_multi.md
Name: lcd_bias_pwm_multi

Overview:
- Multi-channel, parametrised PWM generator for LCD bias and contrast voltages in the Pico LCD driver path. It succeeds the fixed 3-phase, 2-bit, single-channel PWM.
- Each channel turns an N-bit level code into a duty of level/(2^N-1). An RC filter downstream averages the output.
- Adds a programmable phase prescaler, a global enable, and glitch-free duty updates latched only at period boundaries. Also adds a period-start strobe for the LCD frame logic and per-channel output inversion.

Parameters:
- CHANNELS, 4, number of independent PWM outputs sharing one phase counter.
- LEVEL_W, 2, level code width. Period = MAXL = 2^LEVEL_W-1 phases.
- DIV_W, 8, prescaler width.
- INVERT, {CHANNELS{1'b0}}, per-channel output polarity mask. Bit i = 1 inverts channel i, including its idle level.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- en  in  1  run enable, sampled on clk.
- prescale  in  DIV_W  each phase lasts prescale+1 clk cycles.
- level  in  CHANNELS*LEVEL_W  channel i code at [i*LEVEL_W +: LEVEL_W].
- pwm_out  out  CHANNELS  registered PWM outputs.
- period_start  out  1  one-cycle pulse on the first cycle of every period.

Behaviour:
- Reset: rstn low asynchronously clears the following.
  - div_cnt=0, phase=0, shadow levels=0, armed=0, period_start=0.
  - pwm_out=INVERT (idle level).
  - Reset mid-period aborts immediately with no partial pulse. Operation restarts as from power-up.
- Internal state:
  - div_cnt[DIV_W], phase (0..MAXL-1), shadow[CHANNELS][LEVEL_W], armed.
- en=0 at an edge:
  - div_cnt<=0, phase<=0, armed<=0, period_start<=0.
  - pwm_out<=INVERT on that edge (idle next cycle). Shadow is held.
- en=1 and armed=0 (start):
  - shadow<=level, phase<=0, div_cnt<=0, armed<=1, period_start<=1.
- en=1 and armed=1:
  - tick = (div_cnt >= prescale). Using >= means a prescale lowered mid-count takes effect without waiting for wrap.
  - On tick: div_cnt<=0. Otherwise div_cnt<=div_cnt+1.
  - On tick with phase==MAXL-1 (wrap): phase<=0, shadow<=level (all channels together), period_start<=1.
  - On tick without wrap: phase<=phase+1, period_start<=0.
  - Without tick: phase and shadow hold, period_start<=0.
- Output rule, holding in every cycle after the edge that produced the state:
  - pwm_out[i] = (armed && phase < shadow[i]) XOR INVERT[i].
  - The flop is loaded from next-state values, so the output is aligned with phase and carries no extra latency.
  - Level 0 gives constant low. Level MAXL gives constant high with no gap at wrap.
  - Channel i is high for exactly shadow[i]*(prescale+1) cycles per period, starting at phase 0 (left-aligned).
- Level changes:
  - level is ignored except at start and at wrap, so a mid-period change never truncates or extends a pulse.
- prescale:
  - Sampled every cycle. Changing it mid-phase affects only the current and later phases.
- Simultaneous events:
  - en falling on a wrap edge: disable wins, with no shadow load and no period_start.
  - rstn overrides everything.
- Arithmetic:
  - phase compare is unsigned LEVEL_W bits.
  - div_cnt never exceeds prescale+1 and never wraps past 2^DIV_W-1, because >= resets it.

Test Plan:
1. Defaults, prescale=0, level={3,2,1,0} (ch3..ch0), en=1 after reset → from the start cycle, per 3-cycle period:
   - ch0 = 000, ch1 = 100, ch2 = 110, ch3 = 111.
   - period_start high on cycles 0, 3, 6, …
2. Level update: ch1 level 1→2 written at phase 1 → current period stays 100, next period 110. A write at phase 2 gives the same result.
3. Prescale: prescale=2, ch1=2 → period 9 cycles, ch1 high 6, low 3. period_start every 9 cycles. Dropping prescale to 0 mid-phase ends that phase on the next cycle.
4. Enable: en=0 mid-period → pwm_out=INVERT next cycle, period_start quiet. en=1 again → restart at phase 0 with a new shadow and a period_start pulse. en falling on a wrap edge → no pulse.
5. Reset and polarity: rstn asserted mid-high-pulse → pwm_out=INVERT immediately (asynchronously). With INVERT=4'b0001 and ch0 level 1 → ch0 = 011, idle high.
6. LEVEL_W=3, CHANNELS=2, prescale=0: level 5 → 7-cycle period, 5 high then 2 low. Level 7 → constant high across wraps.
